// File: rtl/multicycle_datapath_if.sv
// Bus between the multicycle controller/memory side and the datapath:
// memory port, instruction/flag feedback and all datapath steering controls.
interface multicycle_datapath_if;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;

    modport master (
        output ReadData, PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl,
        input  Adr, WriteData, Instr, ALUFlags
    );

    modport slave (
        input  ReadData, PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl,
        output Adr, WriteData, Instr, ALUFlags
    );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle ARM-subset datapath: PC, IR, Data/A/WriteData/ALUOut staging
// registers, 15-entry register file, extender and NZCV ALU, steered externally.
module multicycle_datapath (
    input logic                  clk,
    input logic                  reset,
    multicycle_datapath_if.slave bus
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] a_q, a_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] rf_q [15];
    logic [31:0] rf_d [15];

    logic [3:0]  ra1, ra2, wa3;
    logic [31:0] rd1, rd2, ext_imm, src_a, src_b, src_b_eff, alu_result, result;
    logic [32:0] sum;
    logic        is_sub, carry, ovf;

    always_comb begin
        ra1 = bus.RegSrc[0] ? 4'd15 : instr_q[19:16];
        ra2 = bus.RegSrc[1] ? instr_q[15:12] : instr_q[3:0];
        wa3 = instr_q[15:12];

        case (bus.ImmSrc)
            2'b00:   ext_imm = {24'd0, instr_q[7:0]};
            2'b01:   ext_imm = {20'd0, instr_q[11:0]};
            2'b10:   ext_imm = {{6{instr_q[23]}}, instr_q[23:0], 2'b00};
            default: ext_imm = 32'd0;
        endcase

        case (bus.ALUSrcA)
            2'b01:   src_a = pc_q;
            2'b10:   src_a = aluout_q;
            default: src_a = a_q;
        endcase

        case (bus.ALUSrcB)
            2'b00:   src_b = wd_q;
            2'b01:   src_b = ext_imm;
            2'b10:   src_b = 32'd4;
            default: src_b = 32'd0;
        endcase

        // Subtract as A + ~B + 1 so carry-out doubles as the no-borrow flag.
        is_sub    = (bus.ALUControl == 2'b01);
        src_b_eff = is_sub ? ~src_b : src_b;
        sum       = {1'b0, src_a} + {1'b0, src_b_eff} + {32'd0, is_sub};

        case (bus.ALUControl)
            2'b10: begin
                alu_result = src_a & src_b;
                carry      = 1'b0;
                ovf        = 1'b0;
            end
            2'b11: begin
                alu_result = src_a | src_b;
                carry      = 1'b0;
                ovf        = 1'b0;
            end
            default: begin
                alu_result = sum[31:0];
                carry      = sum[32];
                ovf        = (src_a[31] == src_b_eff[31]) && (sum[31] != src_a[31]);
            end
        endcase

        case (bus.ResultSrc)
            2'b00:   result = aluout_q;
            2'b01:   result = data_q;
            default: result = alu_result;
        endcase

        // R15 is not stored; reading it returns the current Result (PC path).
        rd1 = (ra1 == 4'd15) ? result : rf_q[ra1];
        rd2 = (ra2 == 4'd15) ? result : rf_q[ra2];
    end

    always_comb begin
        pc_d     = bus.PCWrite ? result : pc_q;
        instr_d  = bus.IRWrite ? bus.ReadData : instr_q;
        data_d   = bus.ReadData;
        a_d      = rd1;
        wd_d     = rd2;
        aluout_d = alu_result;
        rf_d     = rf_q;
        if (bus.RegWrite && !reset && (wa3 != 4'd15)) begin
            rf_d[wa3] = result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= 32'd0;
            instr_q  <= 32'd0;
            data_q   <= 32'd0;
            a_q      <= 32'd0;
            wd_q     <= 32'd0;
            aluout_q <= 32'd0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            a_q      <= a_d;
            wd_q     <= wd_d;
            aluout_q <= aluout_d;
        end
    end

    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

    assign bus.Adr       = bus.AdrSrc ? result : pc_q;
    assign bus.WriteData = wd_q;
    assign bus.Instr     = instr_q;
    assign bus.ALUFlags  = {alu_result[31], (alu_result == 32'd0), carry, ovf};
endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: directed scenarios plus randomized control
// sequences compared against an arithmetic reference model of the datapath.
module tb_multicycle_datapath;
    logic clk = 1'b0;
    logic reset;

    multicycle_datapath_if bus();
    multicycle_datapath dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic [31:0] m_pc, m_ir, m_data, m_a, m_wd, m_aluout;
    logic [31:0] m_rf [15];
    logic [31:0] e_adr, e_result, e_alu, e_rd1, e_rd2;
    logic [3:0]  e_flags;

    task automatic model_eval();
        logic [31:0] ext, sa, sb;
        logic [3:0]  r1, r2;
        longint      full, sv;
        logic        c, v;
        case (bus.ImmSrc)
            2'b00: ext = m_ir & 32'h0000_00FF;
            2'b01: ext = m_ir & 32'h0000_0FFF;
            2'b10: begin
                full = longint'(m_ir[23:0]);
                if (m_ir[23]) full = full - 64'sh100_0000;
                ext = 32'(full * 4);
            end
            default: ext = 32'd0;
        endcase
        sa = (bus.ALUSrcA == 2'b01) ? m_pc : (bus.ALUSrcA == 2'b10) ? m_aluout : m_a;
        sb = (bus.ALUSrcB == 2'b00) ? m_wd : (bus.ALUSrcB == 2'b01) ? ext :
             (bus.ALUSrcB == 2'b10) ? 32'd4 : 32'd0;
        c = 1'b0;
        v = 1'b0;
        case (bus.ALUControl)
            2'b00: begin
                full  = longint'(sa) + longint'(sb);
                e_alu = full[31:0];
                c     = full >= 64'sh1_0000_0000;
                sv    = longint'($signed(sa)) + longint'($signed(sb));
                v     = (sv > SMAX) || (sv < SMIN);
            end
            2'b01: begin
                full  = longint'(sa) - longint'(sb);
                e_alu = full[31:0];
                c     = sa >= sb;
                sv    = longint'($signed(sa)) - longint'($signed(sb));
                v     = (sv > SMAX) || (sv < SMIN);
            end
            2'b10: e_alu = sa & sb;
            default: e_alu = sa | sb;
        endcase
        e_flags  = {e_alu[31], e_alu == 32'd0, c, v};
        e_result = (bus.ResultSrc == 2'b00) ? m_aluout : (bus.ResultSrc == 2'b01) ? m_data : e_alu;
        r1 = bus.RegSrc[0] ? 4'd15 : m_ir[19:16];
        r2 = bus.RegSrc[1] ? m_ir[15:12] : m_ir[3:0];
        e_rd1 = (r1 == 4'd15) ? e_result : m_rf[r1];
        e_rd2 = (r2 == 4'd15) ? e_result : m_rf[r2];
        e_adr = bus.AdrSrc ? e_result : m_pc;
    endtask

    task automatic model_clock();
        if (reset) begin
            m_pc = 32'd0; m_ir = 32'd0; m_data = 32'd0;
            m_a = 32'd0; m_wd = 32'd0; m_aluout = 32'd0;
        end else begin
            if (bus.RegWrite && m_ir[15:12] != 4'd15) m_rf[m_ir[15:12]] = e_result;
            if (bus.PCWrite) m_pc = e_result;
            if (bus.IRWrite) m_ir = bus.ReadData;
            m_data = bus.ReadData; m_a = e_rd1; m_wd = e_rd2; m_aluout = e_alu;
        end
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic ctl(input logic pcw, input logic rw, input logic irw, input logic asrc,
                       input logic [1:0] rs, input logic [1:0] asa, input logic [1:0] asb,
                       input logic [1:0] rsrc, input logic [1:0] imm, input logic [1:0] aluc,
                       input logic [31:0] rd);
        bus.PCWrite = pcw; bus.RegWrite = rw; bus.IRWrite = irw; bus.AdrSrc = asrc;
        bus.RegSrc = rs; bus.ALUSrcA = asa; bus.ALUSrcB = asb; bus.ResultSrc = rsrc;
        bus.ImmSrc = imm; bus.ALUControl = aluc; bus.ReadData = rd;
    endtask

    task automatic load_ir(input logic [31:0] word);
        ctl(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, word);
        cycle();
    endtask

    task automatic write_reg(input logic [3:0] rd, input logic [31:0] val);
        load_ir({16'd0, rd, 12'd0});
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, val);
        cycle();
        ctl(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 32'd0);
        cycle();
    endtask

    task automatic init_regfile();
        reset = 1'b1;
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0);
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            write_reg(4'(i), (i == 0) ? 32'd0 : (i == 2) ? 32'h7FFF_FFFF :
                             (i == 4) ? 32'hFFFF_FFFC : $urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ctl(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 32'hDEAD_BEEF);
        cycle();
        cycle();
        n_tests++; if (bus.Adr !== 32'd0) begin n_fail++; $display("FAIL reset_adr: got %h want %h", bus.Adr, 32'd0); end
        n_tests++; if (bus.Instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", bus.Instr, 32'd0); end
        n_tests++; if (bus.WriteData !== 32'd0) begin n_fail++; $display("FAIL reset_wd: got %h want %h", bus.WriteData, 32'd0); end
        reset = 1'b0;
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 32'd0);
        cycle();
        n_tests++; if (bus.Adr !== 32'd0) begin n_fail++; $display("FAIL reset_pc_hold: got %h want %h", bus.Adr, 32'd0); end
    endtask

    task automatic test_fetch();
        ctl(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 32'hE280_1005);
        cycle();
        n_tests++; if (bus.Instr !== 32'hE280_1005) begin n_fail++; $display("FAIL fetch_instr: got %h want %h", bus.Instr, 32'hE280_1005); end
        n_tests++; if (bus.Adr !== 32'd4) begin n_fail++; $display("FAIL fetch_pc: got %h want %h", bus.Adr, 32'd4); end
    endtask

    task automatic test_add_imm();
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 32'd0);
        cycle();
        ctl(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 32'd0);
        #1;
        n_tests++; if (bus.Adr !== 32'd5) begin n_fail++; $display("FAIL add_aluout: got %h want %h", bus.Adr, 32'd5); end
        cycle();
        load_ir(32'h0001_0001);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0);
        cycle();
        n_tests++; if (bus.WriteData !== 32'd5) begin n_fail++; $display("FAIL add_r1_rd2: got %h want %h", bus.WriteData, 32'd5); end
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 32'd0);
        #1;
        n_tests++; if (bus.Adr !== 32'd5) begin n_fail++; $display("FAIL add_r1_rd1: got %h want %h", bus.Adr, 32'd5); end
        cycle();
    endtask

    task automatic test_sub_flags();
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 32'd0);
        #1;
        n_tests++; if (bus.ALUFlags !== 4'b0110) begin n_fail++; $display("FAIL sub_flags: got %b want %b", bus.ALUFlags, 4'b0110); end
        n_tests++; if (bus.Adr !== 32'd0) begin n_fail++; $display("FAIL sub_result: got %h want %h", bus.Adr, 32'd0); end
        cycle();
    endtask

    task automatic test_overflow();
        load_ir(32'h0002_0001);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0);
        cycle();
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 32'd0);
        #1;
        n_tests++; if (bus.Adr !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_result: got %h want %h", bus.Adr, 32'h8000_0000); end
        n_tests++; if (bus.ALUFlags !== 4'b1001) begin n_fail++; $display("FAIL ovf_flags: got %b want %b", bus.ALUFlags, 4'b1001); end
        cycle();
    endtask

    task automatic test_load_store();
        load_ir(32'h0000_3040);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0);
        cycle();
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 32'd0);
        cycle();
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 32'h0000_1234);
        #1;
        n_tests++; if (bus.Adr !== 32'h40) begin n_fail++; $display("FAIL ldr_adr: got %h want %h", bus.Adr, 32'h40); end
        cycle();
        ctl(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 32'd0);
        #1;
        n_tests++; if (bus.Adr !== 32'h1234) begin n_fail++; $display("FAIL ldr_data: got %h want %h", bus.Adr, 32'h1234); end
        cycle();
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0);
        cycle();
        n_tests++; if (bus.WriteData !== 32'h1234) begin n_fail++; $display("FAIL str_wd: got %h want %h", bus.WriteData, 32'h1234); end
    endtask

    task automatic test_branch();
        logic [31:0] pc0;
        load_ir(32'hEAFF_FFFE);
        pc0 = m_pc;
        ctl(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 32'd0);
        #1;
        n_tests++; if (bus.Adr !== pc0 - 32'd8) begin n_fail++; $display("FAIL br_target: got %h want %h", bus.Adr, pc0 - 32'd8); end
        cycle();
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0);
        #1;
        n_tests++; if (bus.Adr !== pc0 - 32'd8) begin n_fail++; $display("FAIL br_pc: got %h want %h", bus.Adr, pc0 - 32'd8); end
    endtask

    task automatic test_r15_read();
        logic [31:0] pc1;
        pc1 = m_pc;
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 32'd0);
        cycle();
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 32'd0);
        #1;
        n_tests++; if (bus.Adr !== pc1 + 32'd4) begin n_fail++; $display("FAIL r15_rd1: got %h want %h", bus.Adr, pc1 + 32'd4); end
        cycle();
    endtask

    task automatic test_wrap();
        load_ir(32'h0004_0000);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0);
        cycle();
        ctl(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 32'd0);
        cycle();
        ctl(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 32'd0);
        #1;
        n_tests++; if (bus.Adr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", bus.Adr, 32'hFFFF_FFFC); end
        n_tests++; if (bus.ALUFlags !== 4'b0110) begin n_fail++; $display("FAIL wrap_flags: got %b want %b", bus.ALUFlags, 4'b0110); end
        cycle();
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0);
        #1;
        n_tests++; if (bus.Adr !== 32'd0) begin n_fail++; $display("FAIL wrap_zero: got %h want %h", bus.Adr, 32'd0); end
    endtask

    task automatic test_write_r15();
        load_ir(32'h0000_F000);
        ctl(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 32'd0);
        cycle();
        for (int i = 0; i < 15; i++) begin
            load_ir({16'd0, 4'(i), 12'd0});
            ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0);
            cycle();
            n_tests++; if (bus.WriteData !== m_rf[i]) begin n_fail++; $display("FAIL r15_nowrite R%0d: got %h want %h", i, bus.WriteData, m_rf[i]); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 19) == 0);
            ctl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), $urandom);
            #1;
            model_eval();
            n_tests++; if (bus.Adr !== e_adr) begin n_fail++; $display("FAIL rnd_adr #%0d: got %h want %h", k, bus.Adr, e_adr); end
            n_tests++; if (bus.ALUFlags !== e_flags) begin n_fail++; $display("FAIL rnd_flags #%0d: got %b want %b", k, bus.ALUFlags, e_flags); end
            cycle();
            n_tests++; if (bus.Instr !== m_ir) begin n_fail++; $display("FAIL rnd_instr #%0d: got %h want %h", k, bus.Instr, m_ir); end
            n_tests++; if (bus.WriteData !== m_wd) begin n_fail++; $display("FAIL rnd_wd #%0d: got %h want %h", k, bus.WriteData, m_wd); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        init_regfile();
        test_reset();
        test_fetch();
        test_add_imm();
        test_sub_flags();
        test_overflow();
        test_load_store();
        test_branch();
        test_r15_read();
        test_wrap();
        test_write_r15();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
